// File: rtl/writer_if.sv
// Handshake and RAM-write bundle between the frame writer, the MERGE stage
// and the shared frame RAM.
interface writer_if;
   logic [17:0] din;
   logic        RXen;
   logic        reqMFK;
   logic        reqMERGE;
   logic [17:0] dout;
   logic [6:0]  addrWR;
   logic        writeEN;
   logic        TXdone;
   logic [1:0]  cntStream;
   logic [5:0]  addrMEM;

   modport master (
      input  din, RXen, reqMFK,
      output reqMERGE, dout, addrWR, writeEN, TXdone, cntStream, addrMEM
   );

   modport slave (
      output din, RXen, reqMFK,
      input  reqMERGE, dout, addrWR, writeEN, TXdone, cntStream, addrMEM
   );
endinterface

// File: rtl/writer.sv
// MFK frame writer: gathers 48 words from MERGE, then copies them into one
// 64-word page of the shared frame RAM, alternating pages every frame.
module writer (
   input  logic     clk,
   input  logic     RST,
   writer_if.master bus
);

   typedef enum logic [2:0] {REQ, ACKLOW, MFKHIGH, WRITE, MFKLOW} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_word_q, cnt_word_d;
   logic [3:0]  cnt16_q, cnt16_d;
   logic        page_q, page_d;
   logic [2:0]  wr_q, wr_d;
   logic        req_merge_q, req_merge_d;
   logic [17:0] dout_q, dout_d;
   logic [6:0]  addr_wr_q, addr_wr_d;
   logic        write_en_q, write_en_d;
   logic        tx_done_q, tx_done_d;
   logic [1:0]  cnt_stream_q, cnt_stream_d;
   logic [5:0]  addr_mem_q, addr_mem_d;

   // Local frame buffer; deliberately outside the reset domain.
   logic [17:0] mem_q [0:47];
   logic        mem_we;
   logic [5:0]  mem_idx;
   logic [17:0] mem_wdata;

   always_comb begin
      state_d      = state_q;
      cnt_word_d   = cnt_word_q;
      cnt16_d      = cnt16_q;
      page_d       = page_q;
      wr_d         = wr_q;
      req_merge_d  = req_merge_q;
      dout_d       = dout_q;
      addr_wr_d    = addr_wr_q;
      write_en_d   = write_en_q;
      tx_done_d    = tx_done_q;
      cnt_stream_d = cnt_stream_q;
      addr_mem_d   = addr_mem_q;
      mem_we       = 1'b0;
      mem_idx      = cnt_word_q;
      mem_wdata    = bus.din;

      case (state_q)
         REQ: begin
            req_merge_d = 1'b1;
            if (req_merge_q && bus.RXen) begin
               mem_we      = 1'b1;
               cnt_word_d  = cnt_word_q + 6'd1;
               req_merge_d = 1'b0;
               state_d     = ACKLOW;
            end
         end
         ACKLOW: begin
            if (!bus.RXen)
               state_d = (cnt_word_q == 6'd48) ? MFKHIGH : REQ;
         end
         MFKHIGH: begin
            if (bus.reqMFK) begin
               state_d    = WRITE;
               wr_d       = 3'd0;
               addr_mem_d = 6'd0;
            end
         end
         WRITE: begin
            wr_d = wr_q + 3'd1;
            case (wr_q)
               3'd0: begin
                  dout_d    = mem_q[addr_mem_q];
                  addr_wr_d = {page_q, addr_mem_q};
               end
               3'd1: write_en_d = 1'b1;
               3'd3: write_en_d = 1'b0;
               3'd4: begin
                  mem_we     = 1'b1;
                  mem_idx    = addr_mem_q;
                  mem_wdata  = 18'd0;
                  addr_mem_d = addr_mem_q + 6'd1;
                  cnt16_d    = cnt16_q + 4'd1;
                  // The last stream boundary must not show a phantom stream 3.
                  if (cnt16_q == 4'd15 && cnt_stream_q != 2'd2)
                     cnt_stream_d = cnt_stream_q + 2'd1;
               end
               3'd5: begin
                  if (addr_mem_q == 6'd48) begin
                     tx_done_d    = 1'b1;
                     page_d       = ~page_q;
                     addr_mem_d   = 6'd0;
                     cnt_stream_d = 2'd0;
                     cnt_word_d   = 6'd0;
                     state_d      = MFKLOW;
                  end else begin
                     wr_d = 3'd0;
                  end
               end
               default: ;
            endcase
         end
         MFKLOW: begin
            tx_done_d = 1'b0;
            if (!bus.reqMFK) state_d = REQ;
         end
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q      <= REQ;
         cnt_word_q   <= 6'd0;
         cnt16_q      <= 4'd0;
         page_q       <= 1'b0;
         wr_q         <= 3'd0;
         req_merge_q  <= 1'b0;
         dout_q       <= 18'd0;
         addr_wr_q    <= 7'd0;
         write_en_q   <= 1'b0;
         tx_done_q    <= 1'b0;
         cnt_stream_q <= 2'd0;
         addr_mem_q   <= 6'd0;
      end else begin
         state_q      <= state_d;
         cnt_word_q   <= cnt_word_d;
         cnt16_q      <= cnt16_d;
         page_q       <= page_d;
         wr_q         <= wr_d;
         req_merge_q  <= req_merge_d;
         dout_q       <= dout_d;
         addr_wr_q    <= addr_wr_d;
         write_en_q   <= write_en_d;
         tx_done_q    <= tx_done_d;
         cnt_stream_q <= cnt_stream_d;
         addr_mem_q   <= addr_mem_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_idx] <= mem_wdata;
   end

   assign bus.reqMERGE  = req_merge_q;
   assign bus.dout      = dout_q;
   assign bus.addrWR    = addr_wr_q;
   assign bus.writeEN   = write_en_q;
   assign bus.TXdone    = tx_done_q;
   assign bus.cntStream = cnt_stream_q;
   assign bus.addrMEM   = addr_mem_q;

endmodule

// File: tb/tb_writer.sv
// Directed bench for writer: acts as MERGE and MFK, and records every RAM
// write strobe for comparison against hand-derived addresses and data.
module tb_writer;
   logic clk = 1'b0;
   logic RST = 1'b0;
   int   checks = 0;
   int   errors = 0;

   writer_if w();
   writer dut (.clk(clk), .RST(RST), .bus(w.master));

   always #5 clk = ~clk;

   // Write monitor: one entry per writeEN rise, sampled on the falling edge.
   logic [6:0]  q_addr [$];
   logic [17:0] q_data [$];
   logic [1:0]  q_strm [$];
   int          tx_cnt = 0;
   int          bad_len = 0;
   int          we_len = 0;
   logic        we_prev = 1'b0;

   always @(negedge clk) begin
      if (w.writeEN === 1'b1 && !we_prev) begin
         q_addr.push_back(w.addrWR);
         q_data.push_back(w.dout);
         q_strm.push_back(w.cntStream);
      end
      if (w.writeEN !== 1'b1 && we_prev && we_len != 2) bad_len++;
      if (w.writeEN === 1'b1) we_len = we_prev ? we_len + 1 : 1;
      else                    we_len = 0;
      if (w.TXdone === 1'b1) tx_cnt++;
      we_prev = (w.writeEN === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [17:0] d, input bit spur);
      int n;
      n = 0;
      @(negedge clk);
      while (w.reqMERGE !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("req_wait", {31'd0, w.reqMERGE}, 32'd1);
      w.din  = d;
      w.RXen = 1'b1;
      n = 0;
      @(negedge clk);
      while (w.reqMERGE !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      chk("ack_fall", {31'd0, w.reqMERGE}, 32'd0);
      w.RXen = 1'b0;
      if (spur) begin
         // DUT has just re-entered REQ; reqMERGE is still low here.
         @(negedge clk);
         chk("spur_req_low", {31'd0, w.reqMERGE}, 32'd0);
         w.din  = 18'h3ffff;
         w.RXen = 1'b1;
         @(negedge clk);
         w.RXen = 1'b0;
      end
   endtask

   task automatic send_frame(input int base, input bit spur);
      for (int i = 0; i < 48; i++) send_word(18'(base + i), spur && (i != 47));
   endtask

   task automatic wait_tx();
      int n;
      n = 0;
      while (w.TXdone !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      chk("txdone_seen", {31'd0, w.TXdone}, 32'd1);
   endtask

   task automatic do_write();
      @(negedge clk);
      w.reqMFK = 1'b1;
      wait_tx();
      @(negedge clk);
      w.reqMFK = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int abase, input int dbase);
      chk({tag, "_count"}, q_addr.size(), 48);
      if (q_addr.size() == 48)
         for (int i = 0; i < 48; i++) begin
            chk({tag, "_addr"}, {25'd0, q_addr[i]}, abase + i);
            chk({tag, "_data"}, {14'd0, q_data[i]}, dbase + i);
            chk({tag, "_strm"}, {30'd0, q_strm[i]}, i / 16);
         end
      chk({tag, "_txcnt"}, tx_cnt, 1);
      chk({tag, "_welen"}, bad_len, 0);
      q_addr.delete(); q_data.delete(); q_strm.delete();
      tx_cnt = 0;
   endtask

   initial begin
      int n;
      w.din = 18'd0; w.RXen = 1'b0; w.reqMFK = 1'b0;

      // Reset with both inputs asserted
      #1 RST = 1'b1;
      w.reqMFK = 1'b1; w.RXen = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_reqMERGE", {31'd0, w.reqMERGE}, 0);
      chk("rst_dout", {14'd0, w.dout}, 0);
      chk("rst_addrWR", {25'd0, w.addrWR}, 0);
      chk("rst_writeEN", {31'd0, w.writeEN}, 0);
      chk("rst_TXdone", {31'd0, w.TXdone}, 0);
      chk("rst_cntStream", {30'd0, w.cntStream}, 0);
      chk("rst_addrMEM", {26'd0, w.addrMEM}, 0);
      RST = 1'b0; w.reqMFK = 1'b0; w.RXen = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_release_req", {31'd0, w.reqMERGE}, 1);
      chk("rst_no_write", q_addr.size(), 0);

      // Basic frame, with write latency measured from the reqMFK sample
      send_frame(1, 1'b0);
      repeat (2) @(negedge clk);
      chk("mfkhigh_idle", {31'd0, w.writeEN}, 0);
      w.reqMFK = 1'b1;
      @(negedge clk); chk("lat_clk1", {31'd0, w.writeEN}, 0);
      @(negedge clk); chk("lat_clk2", {31'd0, w.writeEN}, 0);
      @(negedge clk); chk("lat_clk3", {31'd0, w.writeEN}, 1);
      wait_tx();
      @(negedge clk);
      chk("tx_one_clk", {31'd0, w.TXdone}, 0);
      w.reqMFK = 1'b0;
      repeat (2) @(negedge clk);
      check_frame("f1", 0, 1);

      // Ping-pong across three frames
      send_frame(100, 1'b0);
      do_write();
      check_frame("f2", 64, 100);
      send_frame(200, 1'b0);
      do_write();
      check_frame("f3", 0, 200);

      // Early MFK: request held high throughout collection
      w.reqMFK = 1'b1;
      for (int i = 0; i < 47; i++) send_word(18'(300 + i), 1'b0);
      chk("early_no_write", q_addr.size(), 0);
      send_word(18'd347, 1'b0);
      wait_tx();
      repeat (5) @(negedge clk);
      chk("early_hold_req", {31'd0, w.reqMERGE}, 0);
      w.reqMFK = 1'b0;
      repeat (2) @(negedge clk);
      chk("early_req_back", {31'd0, w.reqMERGE}, 1);
      check_frame("f4", 64, 300);

      // Spurious acknowledges between every pair of words
      send_frame(500, 1'b1);
      do_write();
      check_frame("f5", 0, 500);

      // Reset during the write of word 20 (page 1 frame)
      send_frame(700, 1'b0);
      @(negedge clk);
      w.reqMFK = 1'b1;
      n = 0;
      while (q_addr.size() < 21 && n < 400) begin @(negedge clk); n++; end
      chk("mid_reached", {31'd0, w.writeEN}, 1);
      #1 RST = 1'b1;
      #1;
      chk("mid_we_drop", {31'd0, w.writeEN}, 0);
      chk("mid_addr_clr", {25'd0, w.addrWR}, 0);
      w.reqMFK = 1'b0;
      repeat (3) @(negedge clk);
      RST = 1'b0;
      bad_len = 0;
      q_addr.delete(); q_data.delete(); q_strm.delete();
      tx_cnt = 0;
      send_frame(900, 1'b0);
      do_write();
      check_frame("f7", 0, 900);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
